// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART receiver and transmitter.
//   - Parity mode codes for the P_UART_CHECK parameter.
//   - Receiver FSM state encoding (plain constants so older tools accept it).
//   - uart_clog2: width helper for the baud-rate divider counter.
package uart_pkg;

  localparam int UART_CHECK_NONE = 0;
  localparam int UART_CHECK_ODD  = 1;
  localparam int UART_CHECK_EVEN = 2;

  localparam logic [2:0] UART_ST_IDLE    = 3'd0;
  localparam logic [2:0] UART_ST_START   = 3'd1;
  localparam logic [2:0] UART_ST_DATA    = 3'd2;
  localparam logic [2:0] UART_ST_PARITY  = 3'd3;
  localparam logic [2:0] UART_ST_STOP    = 3'd4;
  localparam logic [2:0] UART_ST_DELIVER = 3'd5;

  // Never returns less than 1 so a counter declared with it always has a bit.
  function automatic int uart_clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Brings an asynchronous serial line into the clock domain and flags the
// cycle in which the synchronized level goes from 1 to 0.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset; all flops reset to 1 (line idle)
//   i_async  asynchronous serial input
//   o_level  synchronized line level (2 flops of latency)
//   o_fall   one-cycle pulse: previous synced level 1, current 0
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Resetting to 1 means a line that is low when reset releases does not
  // look like a start edge; a real 1 -> 0 transition is required.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// UART receiver: oversamples the serial line with a baud divider, samples
// each bit at mid-bit, assembles the word LSB-first, checks optional parity
// and the stop bits, and hands each word over with a one-cycle valid pulse.
//   i_clk                system clock
//   i_rst_n              asynchronous active-low reset
//   i_uart_rx            serial line, idle high, asynchronous
//   o_usr_rx_data        received word, first bit on the line is bit 0
//   o_usr_rx_valid       one-cycle pulse, data and flags valid
//   o_usr_rx_parity_err  parity mismatch for the delivered word
//   o_usr_rx_frame_err   a sampled stop bit was 0
module uart_rx
  import uart_pkg::*;
#(
  parameter int P_UART_CLK        = 250_000_000,
  parameter int P_UART_BAUDRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_usr_rx_data,
  output logic                         o_usr_rx_valid,
  output logic                         o_usr_rx_parity_err,
  output logic                         o_usr_rx_frame_err
);

  localparam int DIV   = P_UART_CLK / P_UART_BAUDRATE;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = uart_clog2(DIV);

  localparam logic [CNT_W-1:0] C_DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [3:0]       C_DATA_LAST = 4'(P_UART_DATA_WIDTH - 1);
  localparam logic [3:0]       C_STOP_LAST = 4'(P_UART_STOP_WIDTH - 1);

  // With fewer than 4 clocks per bit there is no meaningful mid-bit point.
  if (DIV < 4) begin : g_bad_div
    $error("uart_rx: P_UART_CLK / P_UART_BAUDRATE must be at least 4");
  end
  if (P_UART_DATA_WIDTH < 5 || P_UART_DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_rx: P_UART_DATA_WIDTH must be 5..9");
  end
  if (P_UART_STOP_WIDTH < 1 || P_UART_STOP_WIDTH > 2) begin : g_bad_stop
    $error("uart_rx: P_UART_STOP_WIDTH must be 1 or 2");
  end

  logic w_level;
  logic w_fall;
  logic w_tick;

  logic [2:0]                   r_state;
  logic [CNT_W-1:0]             r_cnt;
  logic [3:0]                   r_bit;
  logic [P_UART_DATA_WIDTH-1:0] r_shift;
  logic                         r_par_acc;
  logic                         r_par_err;
  logic                         r_frm_err;
  logic [P_UART_DATA_WIDTH-1:0] r_data;
  logic                         r_valid;
  logic                         r_par_err_out;
  logic                         r_frm_err_out;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_uart_rx),
    .o_level (w_level),
    .o_fall  (w_fall)
  );

  assign w_tick = (r_cnt == C_DIV_M1);

  // Receive FSM. Outputs are loaded on the edge that leaves STOP, so they
  // are already valid during the single DELIVER cycle. Data enters at the
  // top of the shift register and moves right, so after the last data bit
  // the first bit received sits at bit 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= UART_ST_IDLE;
      r_cnt         <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_par_acc     <= 1'b0;
      r_par_err     <= 1'b0;
      r_frm_err     <= 1'b0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_par_err_out <= 1'b0;
      r_frm_err_out <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        UART_ST_IDLE: begin
          r_cnt     <= '0;
          r_bit     <= '0;
          r_par_acc <= 1'b0;
          r_par_err <= 1'b0;
          r_frm_err <= 1'b0;
          if (w_fall) r_state <= UART_ST_START;
        end
        UART_ST_START: begin
          // A line back high at mid start bit was only a glitch.
          if (r_cnt == C_HALF_M1) begin
            r_cnt   <= '0;
            r_state <= w_level ? UART_ST_IDLE : UART_ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        UART_ST_DATA: begin
          if (w_tick) begin
            r_cnt     <= '0;
            r_shift   <= {w_level, r_shift[P_UART_DATA_WIDTH-1:1]};
            r_par_acc <= r_par_acc ^ w_level;
            if (r_bit == C_DATA_LAST) begin
              r_bit   <= '0;
              r_state <= (P_UART_CHECK != UART_CHECK_NONE) ? UART_ST_PARITY
                                                           : UART_ST_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        UART_ST_PARITY: begin
          // r_par_acc is the XOR of the data bits; folding in the parity
          // bit must give 1 in odd mode and 0 in even mode.
          if (w_tick) begin
            r_cnt <= '0;
            if (P_UART_CHECK == UART_CHECK_ODD) begin
              r_par_err <= ~(r_par_acc ^ w_level);
            end else begin
              r_par_err <= r_par_acc ^ w_level;
            end
            r_state <= UART_ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        UART_ST_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (r_bit == C_STOP_LAST) begin
              r_bit         <= '0;
              r_state       <= UART_ST_DELIVER;
              r_valid       <= 1'b1;
              r_data        <= r_shift;
              r_par_err_out <= r_par_err;
              r_frm_err_out <= r_frm_err | ~w_level;
            end else begin
              r_bit     <= r_bit + 1'b1;
              r_frm_err <= r_frm_err | ~w_level;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        UART_ST_DELIVER: begin
          r_state <= UART_ST_IDLE;
        end
        default: begin
          r_state <= UART_ST_IDLE;
        end
      endcase
    end
  end

  assign o_usr_rx_data       = r_data;
  assign o_usr_rx_valid      = r_valid;
  assign o_usr_rx_parity_err = r_par_err_out;
  assign o_usr_rx_frame_err  = r_frm_err_out;

endmodule

// File: doc/uart_rx.md
# uart_rx

- Serial receiver paired with the project's UART transmitter: same frame format, same parameter set.
- Runs on the system clock and oversamples the asynchronous `i_uart_rx` pin with a baud-rate divider.
- Samples each bit at mid-bit and assembles the data word LSB-first.
- Checks optional parity and the stop bits, then delivers each word to user logic as a one-cycle valid pulse with error flags.

## Interface
- `P_UART_CLK`, 250_000_000, input clock frequency in Hz
- `P_UART_BAUDRATE`, 9600, line baud rate
- `P_UART_DATA_WIDTH`, 8, data bits per frame (5..9)
- `P_UART_STOP_WIDTH`, 1, stop bits per frame (1 or 2)
- `P_UART_CHECK`, 0, parity mode: 0 none, 1 odd, 2 even
- `i_clk`  input  1  system clock, all logic on its rising edge
- `i_rst_n`  input  1  reset, asynchronous, active-low
- `i_uart_rx`  input  1  serial line, idle high, asynchronous to `i_clk`
- `o_usr_rx_data`  output  P_UART_DATA_WIDTH  received word, first bit on line = bit 0
- `o_usr_rx_valid`  output  1  one-cycle pulse, word and flags valid
- `o_usr_rx_parity_err`  output  1  parity mismatch for the delivered word
- `o_usr_rx_frame_err`  output  1  a sampled stop bit was 0

## Operation
- **Divider.**
  - `DIV = P_UART_CLK / P_UART_BAUDRATE` (integer, truncating); `HALF = DIV/2`.
  - The bit counter is `$clog2(DIV)` bits wide.
  - `DIV >= 4` is required; this is enforced by an elaboration-time check.
- **Input.** `i_uart_rx` passes through a 2-flop synchronizer (reset value 1), then a falling-edge detector: previous synced value 1, current 0.
- **FSM states:**
  - **IDLE**
    - Counters cleared.
    - Falling edge -> START.
  - **START**
    - Count to HALF-1, then sample.
    - Sample 1 -> IDLE (glitch rejected, no output).
    - Sample 0 -> DATA, counter cleared.
  - **DATA**
    - At each count DIV-1, shift the sample into bit position [bit index] and clear the counter.
    - After P_UART_DATA_WIDTH samples -> PARITY if `P_UART_CHECK>0`, else STOP.
  - **PARITY**
    - Sample one bit at DIV-1.
    - Error if odd mode and `^data ^ p != 1`.
    - Error if even mode and `^data ^ p != 0`.
    - Go to STOP.
  - **STOP**
    - Sample P_UART_STOP_WIDTH bits at DIV-1 each; any 0 sets frame error.
    - After the last stop sample -> DELIVER.
  - **DELIVER**
    - One cycle: pulse valid and update data and error outputs.
    - Go to IDLE.
- **Bad frames.** A frame with errors is still delivered; its flags are set. No user back-pressure exists; user logic must accept every pulse.
- **Break / line stuck low.** After a frame error, no new start is detected until the line has been seen high. The edge detector enforces this inherently.
- **Parity mode 0.** `o_usr_rx_parity_err` is always 0.

## Timing
- Reset values:
  - `o_usr_rx_data` = 0, `o_usr_rx_valid` = 0, both error flags = 0.
  - FSM in IDLE, synchronizer flops = 1.
- Cycle t0 is the first cycle the synced line reads 0. Measured from t0:
  - start sample at t0+HALF;
  - line bit k (k=0 first data bit, counting data, then parity, then stop bits) sampled at t0+HALF+(k+1)·DIV.
- `o_usr_rx_valid` is high exactly one cycle, the cycle after the last stop-bit sample.
- Pin-to-synced latency is 2 cycles (synchronizer).
- Data and flags update in the valid cycle and hold until the next valid. Flags describe only the word delivered with them.
- Back-to-back frames: IDLE is re-entered about HALF cycles before the end of the stop bit, so a start edge arriving immediately after the stop bit is caught.
- Reset asserted mid-frame:
  - all state and outputs return to reset values immediately;
  - the partial word is discarded;
  - reception resumes on the next falling edge after release.
- Tolerance: receiver/transmitter baud mismatch up to ±2% is received correctly.

## Structure
- Shared package `uart_pkg`:
  - parity constants `UART_CHECK_NONE/ODD/EVEN` (0/1/2);
  - FSM state encoding;
  - clog2 helper for divider width.
- These are shared with the transmitter.
- Sub-module `uart_rx_sync`: 2-flop synchronizer plus falling-edge detector, outputs synced level and edge pulse. Reusable elsewhere.
- Top module: divider counter, bit counter, shift register, parity accumulator, FSM.

## Test plan
Bench parameters `P_UART_CLK=16`, `P_UART_BAUDRATE=1` (DIV=16), 8 data bits.
- No parity, 1 stop, send 0xA5 -> one valid pulse, data 0xA5, both flags 0, pulse timed per the Timing formula.
- Odd parity, send 0x03 with parity bit 1 -> data 0x03, parity_err 0. Same word with parity bit 0 -> parity_err 1.
- Even parity, 2 stop bits, send 0x80 with second stop bit 0 -> data 0x80, frame_err 1; line then held low 50 cycles -> no further valid until line returns high.
- Low glitch of 4 cycles on idle line -> no valid; a following frame 0x5A is received correctly.
- Three back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three valid pulses, correct data, no flags.
- `i_rst_n` low during bit 3 of frame 0x77 -> outputs at reset values; next frame 0x11 received as 0x11.
